fir_inverse_multicycle: RTL and testbench
=========================================

Name: fir_inverse_multicycle

Overview:
- Multicycle all-pole IIR inverse filter: undoes the convolution performed by the team's multicycle FIR.
- Computes y[n] = x[n] − Σ_{k=1..TAPSIZE-1} a[k]·y[n−k] with a monic denominator; a[0]=1 is implicit and not stored.
- Time-multiplexes one signed multiplier over TAPSIZE-1 cycles per sample, in the same Q(WI).(WF) format as the FIR datapath.
- Sits downstream of a channel or FIR stage to recover the original sample stream, e.g. for FIR loopback verification.

Parameters:
- TAPSIZE, 3, denominator length including the implicit a[0]=1; legal range ≥2.
- WI, 1, integer bits of samples and coefficients, sign bit included.
- WF, 15, fraction bits of samples and coefficients.
- GUARD, 4, extra accumulator MSBs; accumulator width W_ACC = 2·(WI+WF)+GUARD.
- ADDRW, 2, coefficient address width; must satisfy 2^ADDRW ≥ TAPSIZE.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- x  in  WI+WF  signed input sample.
- in_valid  in  1  x is valid.
- in_ready  out  1  block can accept a sample; registered.
- clear  in  1  synchronous flush of the y history.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  ADDRW  coefficient index k, 1..TAPSIZE-1.
- coef_data  in  WI+WF  signed coefficient a[k].
- y  out  WI+WF  signed output sample, held until the next output.
- out_valid  out  1  single-cycle pulse: y is new.
- sat  out  1  single-cycle pulse with out_valid when y was clipped.

Behaviour:
- Reset while RST=0, asynchronous and valid mid-operation:
  - state=IDLE; y=0, out_valid=0, sat=0, in_ready=0.
  - All a[k]=0, y history=0, accumulator=0, tap counter=0.
  - Any computation in flight is discarded; no out_valid is produced for it.
- in_ready rises on the first CLK edge after RST is released.
- FSM, three states:
  - IDLE: in_ready=1. On the edge where in_valid=1 and clear=0: acc ← sign-extended x<<WF, k←1, in_ready←0, go to MAC.
  - MAC: one edge per tap: acc ← acc − a[k]·hist[k−1], k←k+1. When k=TAPSIZE-1 has been processed, go to OUT.
  - OUT: round, saturate, register y, shift history (hist[j]←hist[j−1], hist[0]←y), pulse out_valid, in_ready←1, go to IDLE.
- Timing:
  - Sample accepted at edge E0; out_valid is high in the cycle after edge E(TAPSIZE).
  - Latency is TAPSIZE cycles; throughput is one sample per TAPSIZE+1 cycles.
  - out_valid coincides with the next IDLE cycle, so back-to-back acceptance is possible.
- Arithmetic:
  - Products are full-precision Q(2WI).(2WF), accumulated into a W_ACC-bit signed accumulator.
  - Rounding: add 2^(WF−1), then arithmetic shift right by WF (round half up).
  - Saturation to [−2^(WI+WF−1), 2^(WI+WF−1)−1]; sat=1 on that output if clipped.
  - The saturated y is the value written into the history, so feedback uses the clipped value.
- Coefficient writes:
  - Accepted only in IDLE.
  - Writes in MAC or OUT are ignored; coefficients stay stable during a computation.
  - coef_addr=0 or ≥TAPSIZE: write ignored.
  - A write and a sample accepted on the same edge: the sample uses the old coefficients; the new value applies from the next sample.
- clear:
  - Honoured only in IDLE: history←0 on that edge.
  - clear and in_valid in the same cycle: clear wins, the sample is not accepted, in_ready stays 1.
  - clear in MAC or OUT is ignored.
- in_valid while in_ready=0: x is not sampled; the source must hold x and in_valid until it is accepted.

Test Plan:
- Reset, then write a[1]=16384 (0.5) and a[2]=0. Apply the impulse x=16384, then x=0 ×3. Required: y=16384, −8192, 4096, −2048; each out_valid exactly 3 cycles after acceptance; sat=0.
- Cascade with the team's FIR (h=[32767, 16384]·scale) feeding this block with a[1]=16384 on random Q1.15 input. Required: output equals the FIR input within ±1 LSB after the history settles.
- Saturation: a[1]=−32767, constant x=24576. Required: y climbs, clips at 32767 with sat=1 on that and following outputs, and never wraps negative. Input x=−32768 with a=0 gives y=−32768, sat=0.
- Rounding: a[1]=16384, history y=−1, x=0. Required: y=1 (0.5 LSB rounds up); with history y=1, y=0.
- Reset mid-MAC: drop RST during the second MAC cycle. Required: out_valid never pulses for that sample; y=0, a[k]=0 and in_ready=0 during reset; in_ready=1 one edge after release.
- Simultaneous events:
  - clear with in_valid in IDLE: sample not accepted, history zeroed.
  - coef_we during MAC: a[k] unchanged; verify by reading the effect on the next sample.

Source files
------------

// File: rtl/fir_inverse_multicycle.sv
// fir_inverse_multicycle
//   All-pole IIR inverse of the multicycle FIR:
//     y[n] = x[n] - sum_{k=1..TAPSIZE-1} a[k] * y[n-k]   (a[0] = 1 implied)
//   One signed multiplier is shared across the taps, one tap per cycle.
//   Samples and coefficients are Q(WI).(WF); products are kept at full
//   precision in a W_ACC-bit accumulator, then rounded half-up and
//   saturated back to Q(WI).(WF).
//
// Ports
//   CLK        clock, rising edge
//   RST        asynchronous reset, active low
//   x          signed input sample
//   in_valid   x is valid
//   in_ready   block can accept a sample (registered)
//   clear      synchronous flush of the y history (IDLE only)
//   coef_we    coefficient write strobe (IDLE only)
//   coef_addr  coefficient index k, 1..TAPSIZE-1
//   coef_data  signed coefficient a[k]
//   y          signed output sample, held until the next output
//   out_valid  one-cycle pulse, y is new
//   sat        one-cycle pulse with out_valid when y was clipped
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for a sample; coefficient writes and clear honoured
// S_MAC  | acc -= a[k] * hist[k-1], one tap per edge, k = 1..TAPSIZE-1
// S_OUT  | round, saturate, register y, shift history, pulse out_valid

module fir_inverse_multicycle #(
  parameter int TAPSIZE = 3,
  parameter int WI      = 1,
  parameter int WF      = 15,
  parameter int GUARD   = 4,
  parameter int ADDRW   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WI+WF-1:0]      x,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  clear,
  input  logic                  coef_we,
  input  logic [ADDRW-1:0]      coef_addr,
  input  logic [WI+WF-1:0]      coef_data,
  output logic [WI+WF-1:0]      y,
  output logic                  out_valid,
  output logic                  sat
);

  localparam int W     = WI + WF;
  localparam int W_ACC = 2 * W + GUARD;
  localparam int NH    = TAPSIZE - 1;

  // Rounding constant 2^(WF-1) and the clip limits, all at accumulator width.
  localparam logic signed [W_ACC-1:0] RND   = {{(W_ACC-WF){1'b0}}, 1'b1, {(WF-1){1'b0}}};
  localparam logic signed [W_ACC-1:0] Y_MAX = {{(W_ACC-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [W_ACC-1:0] Y_MIN = {{(W_ACC-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t                  state;
  logic [W-1:0]            coef [1:NH];
  logic [W-1:0]            hist [0:NH-1];
  logic signed [W_ACC-1:0] acc;
  logic [ADDRW-1:0]        k;

  logic [W-1:0]            coef_sel;
  logic [W-1:0]            hist_sel;
  logic signed [2*W-1:0]   prod;
  logic signed [W_ACC-1:0] prod_ext;
  logic signed [W_ACC-1:0] x_ext;
  logic signed [W_ACC-1:0] acc_rnd;
  logic signed [W_ACC-1:0] acc_shr;
  logic                    ovf_hi;
  logic                    ovf_lo;
  logic [W-1:0]            y_sat;

  // Tap select: explicit compare keeps every index in range for any TAPSIZE.
  always_comb begin
    coef_sel = '0;
    hist_sel = '0;
    for (int i = 1; i <= NH; i++) begin
      if (k == ADDRW'(i)) begin
        coef_sel = coef[i];
        hist_sel = hist[i-1];
      end
    end
  end

  always_comb begin
    prod     = $signed(coef_sel) * $signed(hist_sel);
    prod_ext = {{GUARD{prod[2*W-1]}}, prod};
    // x aligned to the product binary point (x << WF), sign-extended.
    x_ext    = {{(WI+GUARD){x[W-1]}}, x, {WF{1'b0}}};
    acc_rnd  = acc + RND;
    acc_shr  = acc_rnd >>> WF;
    ovf_hi   = (acc_shr > Y_MAX);
    ovf_lo   = (acc_shr < Y_MIN);
    if (ovf_hi) begin
      y_sat = Y_MAX[W-1:0];
    end else if (ovf_lo) begin
      y_sat = Y_MIN[W-1:0];
    end else begin
      y_sat = acc_shr[W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      acc       <= '0;
      k         <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      in_ready  <= 1'b0;
      for (int i = 1; i <= NH; i++) begin
        coef[i] <= '0;
      end
      for (int j = 0; j < NH; j++) begin
        hist[j] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      sat       <= 1'b0;
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          // Address 0 and addresses >= TAPSIZE match no slot and drop out.
          if (coef_we) begin
            for (int i = 1; i <= NH; i++) begin
              if (coef_addr == ADDRW'(i)) begin
                coef[i] <= coef_data;
              end
            end
          end
          // clear takes priority over a simultaneous sample.
          if (clear) begin
            for (int j = 0; j < NH; j++) begin
              hist[j] <= '0;
            end
          end else if (in_valid && in_ready) begin
            acc      <= x_ext;
            k        <= ADDRW'(1);
            in_ready <= 1'b0;
            state    <= S_MAC;
          end
        end

        S_MAC: begin
          acc <= acc - prod_ext;
          if (k == ADDRW'(NH)) begin
            state <= S_OUT;
          end else begin
            k <= k + 1'b1;
          end
        end

        S_OUT: begin
          y         <= y_sat;
          sat       <= ovf_hi | ovf_lo;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          // Feedback uses the clipped value.
          hist[0]   <= y_sat;
          for (int j = 1; j < NH; j++) begin
            hist[j] <= hist[j-1];
          end
          k     <= '0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_inverse_multicycle.sv
// Scoreboard bench for fir_inverse_multicycle (TAPSIZE=3, Q1.15).
// Stimulus pushes the hand-computed expected output (value, sat flag and the
// cycle it must appear in); an independent monitor pops on every out_valid.

module tb_fir_inverse_multicycle;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] x = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        clear = 1'b0;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic [15:0] y;
  logic        out_valid;
  logic        sat;

  fir_inverse_multicycle #(
    .TAPSIZE (3),
    .WI      (1),
    .WF      (15),
    .GUARD   (4),
    .ADDRW   (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .x         (x),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clear     (clear),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .y         (y),
    .out_valid (out_valid),
    .sat       (sat)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] y;
    logic        s;
    int          c;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge CLK);
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out: got y=%0d with out_valid, expected no output", $signed(y));
        end else begin
          e = sb.pop_front();
          chk("y", $signed(y), $signed(e.y));
          chk("sat", {31'd0, sat}, {31'd0, e.s});
          chk("latency_cycle", cyc, e.c);
        end
      end else if (sat) begin
        n_checks++;
        n_errors++;
        $display("FAIL sat_without_valid: got sat=1, expected 0");
      end
    end
  end

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: in_ready=0, expected 1", tag);
    end
  endtask

  task automatic wcoef(input logic [1:0] a, input logic [15:0] d);
    @(negedge CLK);
    wait_ready("wcoef");
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge CLK);
    coef_we = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge CLK);
    wait_ready("clear");
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
  endtask

  // Issue one sample; output expected 3 edges after the accepting edge.
  task automatic send(input int xv, input int ey, input bit es);
    exp_t n;
    @(negedge CLK);
    x        = 16'(xv);
    in_valid = 1'b1;
    wait_ready("send");
    @(posedge CLK);
    #1;
    n.y = 16'(ey);
    n.s = es;
    n.c = cyc + 3;
    sb.push_back(n);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d outputs pending, expected 0", sb.size());
      sb.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    chk("reset_y", $signed(y), 0);
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_sat", {31'd0, sat}, 0);
    chk("reset_in_ready", {31'd0, in_ready}, 0);
    RST = 1'b1;
    #1;
    chk("in_ready_before_edge", {31'd0, in_ready}, 0);
    @(posedge CLK);
    #1;
    chk("in_ready_after_release", {31'd0, in_ready}, 1);

    // Impulse through a[1]=0.5; out-of-range writes must not land anywhere.
    wcoef(2'd1, 16'd16384);
    wcoef(2'd2, 16'd0);
    wcoef(2'd3, 16'd12345);
    wcoef(2'd0, 16'h7fff);
    send(16384, 16384, 0);
    send(0, -8192, 0);
    send(0, 4096, 0);
    send(0, -2048, 0);
    drain();

    // Second tap only: y[n] = x[n] - 0.5*y[n-2]
    do_clear();
    wcoef(2'd1, 16'd0);
    wcoef(2'd2, 16'd16384);
    send(16384, 16384, 0);
    send(0, 0, 0);
    send(0, -8192, 0);
    send(0, 0, 0);
    drain();

    // Rounding half-up
    do_clear();
    wcoef(2'd1, 16'd16384);
    wcoef(2'd2, 16'd0);
    send(-1, -1, 0);
    send(0, 1, 0);
    send(0, 0, 0);
    drain();

    // Coefficient writes during MAC/OUT are ignored
    do_clear();
    send(16384, 16384, 0);
    coef_we   = 1'b1;
    coef_addr = 2'd1;
    coef_data = 16'h8001;
    repeat (3) @(posedge CLK);
    #1;
    coef_we = 1'b0;
    send(0, -8192, 0);
    drain();

    // clear together with in_valid: clear wins, history zeroed
    @(negedge CLK);
    wait_ready("clear_valid");
    x        = 16'd12345;
    in_valid = 1'b1;
    clear    = 1'b1;
    @(negedge CLK);
    chk("clear_wins_in_ready", {31'd0, in_ready}, 1);
    clear    = 1'b0;
    in_valid = 1'b0;
    send(0, 0, 0);
    drain();

    // Saturation with feedback of the clipped value
    do_clear();
    wcoef(2'd1, 16'h8001);
    send(24576, 24576, 0);
    send(24576, 32767, 1);
    send(24576, 32767, 1);
    send(24576, 32767, 1);
    drain();
    wcoef(2'd1, 16'd0);
    do_clear();
    send(-32768, -32768, 0);
    drain();

    // Reset during the second MAC cycle
    wcoef(2'd1, 16'd16384);
    @(negedge CLK);
    x        = 16'd16384;
    in_valid = 1'b1;
    wait_ready("mid_reset");
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("mid_reset_y", $signed(y), 0);
    chk("mid_reset_in_ready", {31'd0, in_ready}, 0);
    chk("mid_reset_out_valid", {31'd0, out_valid}, 0);
    @(posedge CLK);
    #1;
    chk("in_ready_held_in_reset", {31'd0, in_ready}, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("in_ready_after_mid_reset", {31'd0, in_ready}, 1);
    // a[1] must have been cleared: no feedback on the second sample.
    send(16384, 16384, 0);
    send(0, 0, 0);
    drain();

    repeat (5) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
